// File: rtl/mux_nway_stream.sv
// N-way valid/ready stream multiplexer with a registered output stage, static or round-robin grant.
// Optional packet locking is enabled by defining MUX_PKT_LOCK_EN.
module mux_nway_stream #(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 16,
    parameter int SEL_W  = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     mode_i,
    input  logic [SEL_W-1:0]         sel_i,
    input  logic [NUM_CH*DATA_W-1:0] in_data_i,
    input  logic [NUM_CH-1:0]        in_valid_i,
    input  logic [NUM_CH-1:0]        in_last_i,
    output logic [NUM_CH-1:0]        in_ready_o,
    output logic [DATA_W-1:0]        out_data_o,
    output logic [SEL_W-1:0]         out_ch_o,
    output logic                     out_last_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i
);

    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0]  out_ch_q, out_ch_d;
    logic              out_last_q, out_last_d;
    logic              out_valid_q, out_valid_d;
    logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;
`ifdef MUX_PKT_LOCK_EN
    logic              lock_q, lock_d;
    logic [SEL_W-1:0]  lock_ch_q, lock_ch_d;
`endif

    logic              loadEn;
    logic              grantValid;
    logic [SEL_W-1:0]  grantIdx;
    logic              transfer;
    logic [DATA_W-1:0] selData;
    logic              selLast;

    assign loadEn   = !out_valid_q || out_ready_i;
    assign transfer = loadEn && grantValid;

    // Grant selection: an open packet lock overrides both modes; channels are only granted when valid.
    always_comb begin
        grantValid = 1'b0;
        grantIdx   = '0;
`ifdef MUX_PKT_LOCK_EN
        if (lock_q) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (SEL_W'(i) == lock_ch_q && in_valid_i[i]) begin
                    grantValid = 1'b1;
                    grantIdx   = SEL_W'(i);
                end
            end
        end else
`endif
        if (mode_i) begin
            // Two passes give the wrapped search order starting at rr_ptr.
            for (int i = 0; i < NUM_CH; i++) begin
                if (!grantValid && in_valid_i[i] && SEL_W'(i) >= rr_ptr_q) begin
                    grantValid = 1'b1;
                    grantIdx   = SEL_W'(i);
                end
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (!grantValid && in_valid_i[i]) begin
                    grantValid = 1'b1;
                    grantIdx   = SEL_W'(i);
                end
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (SEL_W'(i) == sel_i && in_valid_i[i]) begin
                    grantValid = 1'b1;
                    grantIdx   = SEL_W'(i);
                end
            end
        end
    end

    always_comb begin
        selData    = '0;
        selLast    = 1'b0;
        in_ready_o = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grantValid && grantIdx == SEL_W'(i)) begin
                selData       = in_data_i[i*DATA_W +: DATA_W];
                selLast       = in_last_i[i];
                in_ready_o[i] = loadEn;
            end
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_last_d  = out_last_q;
        out_valid_d = out_valid_q;
        rr_ptr_d    = rr_ptr_q;
`ifdef MUX_PKT_LOCK_EN
        lock_d      = lock_q;
        lock_ch_d   = lock_ch_q;
`endif
        if (loadEn) begin
            out_valid_d = transfer;
        end
        if (transfer) begin
            out_data_d = selData;
            out_ch_d   = grantIdx;
            out_last_d = selLast;
            rr_ptr_d   = (grantIdx == SEL_W'(NUM_CH - 1)) ? '0 : grantIdx + SEL_W'(1);
`ifdef MUX_PKT_LOCK_EN
            lock_d     = !selLast;
            lock_ch_d  = grantIdx;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
`ifdef MUX_PKT_LOCK_EN
            lock_q      <= 1'b0;
            lock_ch_q   <= '0;
`endif
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_last_q  <= out_last_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
`ifdef MUX_PKT_LOCK_EN
            lock_q      <= lock_d;
            lock_ch_q   <= lock_ch_d;
`endif
        end
    end

    assign out_data_o  = out_data_q;
    assign out_ch_o    = out_ch_q;
    assign out_last_o  = out_last_q;
    assign out_valid_o = out_valid_q;

endmodule

// File: tb/tb_mux_nway_stream.sv
// Directed self-checking bench for mux_nway_stream: an 8-channel instance plus a 6-channel one for range checks.
module tb_mux_nway_stream;

    logic          clk;
    logic          rst_n;
    logic          mode;
    logic [2:0]    sel;
    logic [127:0]  inData;
    logic [7:0]    inValid;
    logic [7:0]    inLast;
    logic [7:0]    inReady;
    logic [15:0]   outData;
    logic [2:0]    outCh;
    logic          outLast;
    logic          outValid;
    logic          outReady;

    logic          mode6;
    logic [2:0]    sel6;
    logic [95:0]   inData6;
    logic [5:0]    inValid6;
    logic [5:0]    inLast6;
    logic [5:0]    inReady6;
    logic [15:0]   outData6;
    logic [2:0]    outCh6;
    logic          outLast6;
    logic          outValid6;
    logic          outReady6;

    int nChecks = 0;
    int nFails  = 0;

    mux_nway_stream #(.NUM_CH(8), .DATA_W(16), .SEL_W(3)) dut (
        .clk_i(clk), .rst_ni(rst_n), .mode_i(mode), .sel_i(sel),
        .in_data_i(inData), .in_valid_i(inValid), .in_last_i(inLast),
        .in_ready_o(inReady), .out_data_o(outData), .out_ch_o(outCh),
        .out_last_o(outLast), .out_valid_o(outValid), .out_ready_i(outReady)
    );

    mux_nway_stream #(.NUM_CH(6), .DATA_W(16), .SEL_W(3)) dut6 (
        .clk_i(clk), .rst_ni(rst_n), .mode_i(mode6), .sel_i(sel6),
        .in_data_i(inData6), .in_valid_i(inValid6), .in_last_i(inLast6),
        .in_ready_o(inReady6), .out_data_o(outData6), .out_ch_o(outCh6),
        .out_last_o(outLast6), .out_valid_o(outValid6), .out_ready_i(outReady6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        mode     = 1'b1;
        sel      = 3'd0;
        inValid  = 8'hFF;
        inLast   = 8'hFF;
        outReady = 1'b1;
        for (int i = 0; i < 8; i++) inData[i*16 +: 16] = 16'hA000 + 16'(i);
        mode6     = 1'b0;
        sel6      = 3'd0;
        inValid6  = 6'h00;
        inLast6   = 6'h3F;
        outReady6 = 1'b1;
        for (int i = 0; i < 6; i++) inData6[i*16 +: 16] = 16'hB000 + 16'(i);
        #1;
        nChecks++; if (outValid !== 1'b0) begin nFails++; $display("[TB] FAIL reset_valid: got %b expected 0", outValid); end
        nChecks++; if (outData !== 16'h0) begin nFails++; $display("[TB] FAIL reset_data: got %h expected 0000", outData); end
        nChecks++; if (outCh !== 3'd0) begin nFails++; $display("[TB] FAIL reset_ch: got %0d expected 0", outCh); end
        nChecks++; if (outLast !== 1'b0) begin nFails++; $display("[TB] FAIL reset_last: got %b expected 0", outLast); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        nChecks++; if (inReady !== 8'h01) begin nFails++; $display("[TB] FAIL reset_first_grant: got %h expected 01", inReady); end
        step();
        nChecks++; if (outCh !== 3'd0 || outValid !== 1'b1) begin nFails++; $display("[TB] FAIL reset_first_beat: got ch %0d valid %b expected ch 0 valid 1", outCh, outValid); end
    endtask

    task automatic test_static();
        mode = 1'b0;
        sel  = 3'd3;
        #1;
        nChecks++; if (inReady !== 8'h08) begin nFails++; $display("[TB] FAIL static_ready: got %h expected 08", inReady); end
        for (int n = 0; n < 4; n++) begin
            step();
            nChecks++; if (outData !== 16'hA003 || outCh !== 3'd3 || outValid !== 1'b1) begin
                nFails++; $display("[TB] FAIL static_beat%0d: got data %h ch %0d valid %b expected A003 3 1", n, outData, outCh, outValid);
            end
            nChecks++; if (inReady !== 8'h08) begin nFails++; $display("[TB] FAIL static_ready%0d: got %h expected 08", n, inReady); end
        end
    endtask

    task automatic test_round_robin();
        pulseReset();
        mode = 1'b1;
        for (int n = 0; n < 10; n++) begin
            #1;
            nChecks++; if (inReady !== (8'h01 << (n % 8))) begin
                nFails++; $display("[TB] FAIL rr_ready%0d: got %h expected %h", n, inReady, 8'h01 << (n % 8));
            end
            step();
            nChecks++; if (outCh !== 3'(n % 8) || outData !== 16'hA000 + 16'(n % 8)) begin
                nFails++; $display("[TB] FAIL rr_beat%0d: got ch %0d data %h expected ch %0d", n, outCh, outData, n % 8);
            end
        end
    endtask

    task automatic test_backpressure();
        #1;
        nChecks++; if (inReady !== 8'h04) begin nFails++; $display("[TB] FAIL bp_pre_ready: got %h expected 04", inReady); end
        step();
        nChecks++; if (outCh !== 3'd2) begin nFails++; $display("[TB] FAIL bp_load: got ch %0d expected 2", outCh); end
        outReady = 1'b0;
        #1;
        nChecks++; if (inReady !== 8'h00) begin nFails++; $display("[TB] FAIL bp_ready_low: got %h expected 00", inReady); end
        for (int n = 0; n < 5; n++) begin
            step();
            nChecks++; if (outData !== 16'hA002 || outCh !== 3'd2 || outValid !== 1'b1 || inReady !== 8'h00) begin
                nFails++; $display("[TB] FAIL bp_hold%0d: got data %h ch %0d valid %b ready %h expected A002 2 1 00", n, outData, outCh, outValid, inReady);
            end
        end
        outReady = 1'b1;
        #1;
        nChecks++; if (inReady !== 8'h08) begin nFails++; $display("[TB] FAIL bp_release_ready: got %h expected 08", inReady); end
        step();
        nChecks++; if (outCh !== 3'd3 || outData !== 16'hA003) begin nFails++; $display("[TB] FAIL bp_release: got ch %0d data %h expected 3 A003", outCh, outData); end
    endtask

    task automatic test_range();
        inValid6  = 6'h3F;
        mode6     = 1'b0;
        sel6      = 3'd2;
        outReady6 = 1'b1;
        #1;
        nChecks++; if (inReady6 !== 6'h04) begin nFails++; $display("[TB] FAIL range_ready_sel2: got %h expected 04", inReady6); end
        step();
        nChecks++; if (outValid6 !== 1'b1 || outCh6 !== 3'd2 || outData6 !== 16'hB002) begin
            nFails++; $display("[TB] FAIL range_beat: got valid %b ch %0d data %h expected 1 2 B002", outValid6, outCh6, outData6);
        end
        sel6      = 3'd7;
        outReady6 = 1'b0;
        #1;
        nChecks++; if (inReady6 !== 6'h00) begin nFails++; $display("[TB] FAIL range_ready_sel7: got %h expected 00", inReady6); end
        step();
        nChecks++; if (outValid6 !== 1'b1 || outCh6 !== 3'd2) begin nFails++; $display("[TB] FAIL range_hold: got valid %b ch %0d expected 1 2", outValid6, outCh6); end
        outReady6 = 1'b1;
        #1;
        nChecks++; if (inReady6 !== 6'h00) begin nFails++; $display("[TB] FAIL range_ready_drain: got %h expected 00", inReady6); end
        step();
        nChecks++; if (outValid6 !== 1'b0) begin nFails++; $display("[TB] FAIL range_drained: got valid %b expected 0", outValid6); end
        inValid6 = 6'h00;
    endtask

    task automatic test_lock();
        int expCh [5];
        int cnt1;
        logic expLast;
`ifdef MUX_PKT_LOCK_EN
        expCh = '{0, 1, 1, 1, 2};
`else
        expCh = '{0, 1, 2, 3, 4};
`endif
        cnt1 = 0;
        pulseReset();
        mode    = 1'b1;
        inValid = 8'hFF;
        inLast  = 8'hFF;
        for (int n = 0; n < 5; n++) begin
            inLast[1] = (cnt1 == 2);
            expLast   = (expCh[n] == 1) ? (cnt1 == 2) : 1'b1;
            #1;
            nChecks++; if (inReady !== (8'h01 << expCh[n])) begin
                nFails++; $display("[TB] FAIL lock_ready%0d: got %h expected %h", n, inReady, 8'h01 << expCh[n]);
            end
            step();
            nChecks++; if (outCh !== 3'(expCh[n]) || outLast !== expLast) begin
                nFails++; $display("[TB] FAIL lock_beat%0d: got ch %0d last %b expected ch %0d last %b", n, outCh, outLast, expCh[n], expLast);
            end
            if (expCh[n] == 1) cnt1++;
        end
        inLast = 8'hFF;
    endtask

    task automatic test_midstream_reset();
        outReady = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        nChecks++; if (outValid !== 1'b0 || outData !== 16'h0 || outCh !== 3'd0 || outLast !== 1'b0) begin
            nFails++; $display("[TB] FAIL midreset_outputs: got valid %b data %h ch %0d last %b expected all 0", outValid, outData, outCh, outLast);
        end
        rst_n    = 1'b1;
        outReady = 1'b1;
        #1;
        nChecks++; if (inReady !== 8'h01) begin nFails++; $display("[TB] FAIL midreset_grant: got %h expected 01", inReady); end
        step();
        nChecks++; if (outCh !== 3'd0 || outValid !== 1'b1 || outData !== 16'hA000) begin
            nFails++; $display("[TB] FAIL midreset_beat: got ch %0d valid %b data %h expected 0 1 A000", outCh, outValid, outData);
        end
    endtask

    initial begin
        test_reset();
        test_static();
        test_round_robin();
        test_backpressure();
        test_range();
        test_lock();
        test_midstream_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #200000;
        nFails++;
        $display("[TB] FAIL watchdog: simulation did not complete within time limit");
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
